// File: rtl/round_scheduler.sv
// round_scheduler: sequences the five permutation step units (parity, rotate,
// permute, revaluate, add_rc) over ROUNDS rounds with a per-step watchdog.
module round_scheduler #(
    parameter int unsigned ROUNDS  = 24,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [4:0] step_done,
    output logic [4:0] step_start,
    output logic [4:0] round_idx,
    output logic       ld_fr,
    output logic       ld_fw,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned STEPS  = 5;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned RND_W  = 5;
    localparam int unsigned TMO_W  = 8;

    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(STEPS - 1);
    localparam logic [RND_W-1:0]  LAST_ROUND = RND_W'(ROUNDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GO    = 3'd2,
        WAIT  = 3'd3,
        STORE = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [RND_W-1:0]    round_q, round_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic [STEPS-1:0]    cur_mask;
    logic [STEPS-1:0]    nxt_mask;
    logic                done_hit;

    logic [STEPS-1:0]    step_start_d;
    logic                ld_fr_d;
    logic                ld_fw_d;
    logic                busy_d;
    logic                done_d;
    logic                err_d;

    // Only the completion bit of the unit currently being waited on matters.
    assign cur_mask  = STEPS'(1) << step_q;
    assign nxt_mask  = STEPS'(1) << step_d;
    assign done_hit  = |(step_done & cur_mask);
    assign round_idx = round_q;

    // State and counter registers plus registered Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            round_q    <= '0;
            tmo_q      <= '0;
            step_start <= '0;
            ld_fr      <= 1'b0;
            ld_fw      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            round_q    <= round_d;
            tmo_q      <= tmo_d;
            step_start <= step_start_d;
            ld_fr      <= ld_fr_d;
            ld_fw      <= ld_fw_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    // Next-state and counter update; abort outranks every other transition.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        round_d = round_q;
        tmo_d   = tmo_q;

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            step_d  = '0;
            round_d = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                        step_d  = '0;
                        round_d = '0;
                    end
                end
                LOAD: begin
                    state_d = GO;
                end
                GO: begin
                    tmo_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (done_hit) begin
                        if (step_q < LAST_STEP) begin
                            step_d  = step_q + STEP_W'(1);
                            state_d = GO;
                        end else if (round_q < LAST_ROUND) begin
                            step_d  = '0;
                            round_d = round_q + RND_W'(1);
                            state_d = GO;
                        end else begin
                            state_d = STORE;
                        end
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                        if (tmo_q >= TMO_LAST) begin
                            state_d = ERR;
                        end
                    end
                end
                STORE: begin
                    state_d = IDLE;
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                    round_d = '0;
                    tmo_d   = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the upcoming state so they are flops aligned with it.
    always_comb begin
        step_start_d = '0;
        ld_fr_d      = 1'b0;
        ld_fw_d      = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        if (state_d == GO) begin
            step_start_d = nxt_mask;
        end
        ld_fr_d = (state_d == LOAD);
        ld_fw_d = (state_d == STORE);
        done_d  = (state_d == STORE);
        err_d   = (state_d == ERR);
        busy_d  = (state_d == LOAD) || (state_d == GO) ||
                  (state_d == WAIT) || (state_d == STORE);
    end

endmodule
